// File: rtl/siphash_pkg.sv
// Shared constants, FSM encoding and helpers for the SipHash core.
// The 0xee/0xdd tweaks are only consumed when SIPHASH_LONG_OUTPUT_EN is defined.
package siphash_pkg;

   localparam int unsigned WORD_W = 64;
   localparam int unsigned KEY_W  = 128;
   localparam int unsigned CNT_W  = 4;

   localparam logic [WORD_W-1:0] IV0 = 64'h736f6d6570736575;
   localparam logic [WORD_W-1:0] IV1 = 64'h646f72616e646f6d;
   localparam logic [WORD_W-1:0] IV2 = 64'h6c7967656e657261;
   localparam logic [WORD_W-1:0] IV3 = 64'h7465646279746573;

   localparam logic [7:0] TWEAK_SHORT = 8'hff;
   localparam logic [7:0] TWEAK_LONG  = 8'hee;
   localparam logic [7:0] TWEAK_FIN2  = 8'hdd;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COMP,
      ST_COMP_END,
      ST_FIN,
      ST_FIN2_START,
      ST_OUT
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] v3;
      logic [WORD_W-1:0] v2;
      logic [WORD_W-1:0] v1;
      logic [WORD_W-1:0] v0;
   } sip_state_t;

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x << n) | (x >> (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] fold(input sip_state_t s);
      return s.v0 ^ s.v1 ^ s.v2 ^ s.v3;
   endfunction

endpackage

// File: rtl/siphash_round.sv
// One combinational SipRound over v0..v3; all additions wrap modulo 2^64.
module siphash_round
   import siphash_pkg::*;
(
   input  logic [63:0] v0_in,
   input  logic [63:0] v1_in,
   input  logic [63:0] v2_in,
   input  logic [63:0] v3_in,
   output logic [63:0] v0_out,
   output logic [63:0] v1_out,
   output logic [63:0] v2_out,
   output logic [63:0] v3_out
);

   logic [63:0] a0;
   logic [63:0] a1;
   logic [63:0] a2;
   logic [63:0] a3;
   logic [63:0] b0;
   logic [63:0] b2;

   assign a0 = v0_in + v1_in;
   assign a1 = rotl(v1_in, 13) ^ a0;
   assign a2 = v2_in + v3_in;
   assign a3 = rotl(v3_in, 16) ^ a2;

   // second half-round mixes across the lanes
   assign b0     = rotl(a0, 32) + a3;
   assign b2     = a2 + a1;
   assign v0_out = b0;
   assign v3_out = rotl(a3, 21) ^ b0;
   assign v1_out = rotl(a1, 17) ^ b2;
   assign v2_out = rotl(b2, 32);

endmodule

// File: rtl/siphash_gen2_core.sv
// Iterative SipHash-c-d core with one or two SipRounds per clock.
// Define SIPHASH_LONG_OUTPUT_EN to enable the 128-bit output mode (long_mode).
module siphash_gen2_core
   import siphash_pkg::*;
#(
   parameter int unsigned C_ROUNDS = 2,
   parameter int unsigned D_ROUNDS = 4,
   parameter int unsigned RPC      = 1
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         initialize,
   input  logic         compress,
   input  logic         finalize,
   input  logic         long_mode,
   input  logic [127:0] key,
   input  logic [63:0]  mi,
   output logic         ready,
   output logic [127:0] word,
   output logic         word_valid
);

   state_t            state_q, state_d;
   sip_state_t        v_q, v_d;
   logic [63:0]       mi_q, mi_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [63:0]       word_lo_q, word_lo_d;

`ifdef SIPHASH_LONG_OUTPUT_EN
   logic              long_q, long_d;
   logic              pass2_q, pass2_d;
   logic [63:0]       word_hi_q, word_hi_d;
`else
   logic              unused_long_mode;
   assign unused_long_mode = long_mode;
`endif

   logic [4:0]        total;
   logic [4:0]        cnt_sum;
   logic              use2;
   logic              last;
   sip_state_t        rnd_out;
   logic [63:0]       r1_v0, r1_v1, r1_v2, r1_v3;

   // Round-step bookkeeping: the second round is bypassed when only one remains.
   assign total   = (state_q == ST_COMP) ? 5'(C_ROUNDS) : 5'(D_ROUNDS);
   assign use2    = (RPC == 2) && ((5'(cnt_q) + 5'd2) <= total);
   assign cnt_sum = 5'(cnt_q) + (use2 ? 5'd2 : 5'd1);
   assign last    = (cnt_sum >= total);

   siphash_round u_round0 (
      .v0_in  (v_q.v0), .v1_in  (v_q.v1), .v2_in  (v_q.v2), .v3_in  (v_q.v3),
      .v0_out (r1_v0),  .v1_out (r1_v1),  .v2_out (r1_v2),  .v3_out (r1_v3)
   );

   generate
      if (RPC == 2) begin : g_two
         logic [63:0] r2_v0, r2_v1, r2_v2, r2_v3;
         siphash_round u_round1 (
            .v0_in  (r1_v0), .v1_in  (r1_v1), .v2_in  (r1_v2), .v3_in  (r1_v3),
            .v0_out (r2_v0), .v1_out (r2_v1), .v2_out (r2_v2), .v3_out (r2_v3)
         );
         assign rnd_out = use2 ? {r2_v3, r2_v2, r2_v1, r2_v0} : {r1_v3, r1_v2, r1_v1, r1_v0};
      end else begin : g_one
         assign rnd_out = {r1_v3, r1_v2, r1_v1, r1_v0};
      end
   endgenerate

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      v_d       = v_q;
      mi_d      = mi_q;
      cnt_d     = cnt_q;
      ready_d   = ready_q;
      valid_d   = valid_q;
      word_lo_d = word_lo_q;
`ifdef SIPHASH_LONG_OUTPUT_EN
      long_d    = long_q;
      pass2_d   = pass2_q;
      word_hi_d = word_hi_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (ready_q) begin
               if (initialize) begin
                  v_d.v0    = key[63:0]   ^ IV0;
                  v_d.v1    = key[127:64] ^ IV1;
                  v_d.v2    = key[63:0]   ^ IV2;
                  v_d.v3    = key[127:64] ^ IV3;
                  valid_d   = 1'b0;
                  word_lo_d = '0;
`ifdef SIPHASH_LONG_OUTPUT_EN
                  long_d    = long_mode;
                  word_hi_d = '0;
                  if (long_mode) begin
                     v_d.v1 = (key[127:64] ^ IV1) ^ 64'(TWEAK_LONG);
                  end
`endif
               end else if (compress) begin
                  mi_d    = mi;
                  v_d.v3  = v_q.v3 ^ mi;
                  cnt_d   = '0;
                  ready_d = 1'b0;
                  valid_d = 1'b0;
                  state_d = ST_COMP;
               end else if (finalize) begin
`ifdef SIPHASH_LONG_OUTPUT_EN
                  v_d.v2  = v_q.v2 ^ 64'(long_q ? TWEAK_LONG : TWEAK_SHORT);
                  pass2_d = 1'b0;
`else
                  v_d.v2  = v_q.v2 ^ 64'(TWEAK_SHORT);
`endif
                  cnt_d   = '0;
                  ready_d = 1'b0;
                  valid_d = 1'b0;
                  state_d = ST_FIN;
               end
            end
         end
         ST_COMP: begin
            v_d   = rnd_out;
            cnt_d = CNT_W'(cnt_sum);
            if (last) begin
               cnt_d   = '0;
               state_d = ST_COMP_END;
            end
         end
         ST_COMP_END: begin
            v_d.v0  = v_q.v0 ^ mi_q;
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
         ST_FIN: begin
            v_d   = rnd_out;
            cnt_d = CNT_W'(cnt_sum);
            if (last) begin
               cnt_d   = '0;
`ifdef SIPHASH_LONG_OUTPUT_EN
               state_d = (long_q && !pass2_q) ? ST_FIN2_START : ST_OUT;
`else
               state_d = ST_OUT;
`endif
            end
         end
`ifdef SIPHASH_LONG_OUTPUT_EN
         ST_FIN2_START: begin
            word_lo_d = fold(v_q);
            v_d.v1    = v_q.v1 ^ 64'(TWEAK_FIN2);
            pass2_d   = 1'b1;
            cnt_d     = '0;
            state_d   = ST_FIN;
         end
`endif
         ST_OUT: begin
`ifdef SIPHASH_LONG_OUTPUT_EN
            if (long_q) word_hi_d = fold(v_q);
            else        word_lo_d = fold(v_q);
`else
            word_lo_d = fold(v_q);
`endif
            valid_d = 1'b1;
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         v_q       <= '0;
         mi_q      <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         word_lo_q <= '0;
`ifdef SIPHASH_LONG_OUTPUT_EN
         long_q    <= 1'b0;
         pass2_q   <= 1'b0;
         word_hi_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         v_q       <= v_d;
         mi_q      <= mi_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         word_lo_q <= word_lo_d;
`ifdef SIPHASH_LONG_OUTPUT_EN
         long_q    <= long_d;
         pass2_q   <= pass2_d;
         word_hi_q <= word_hi_d;
`endif
      end
   end

   assign ready      = ready_q;
   assign word_valid = valid_q;
`ifdef SIPHASH_LONG_OUTPUT_EN
   assign word       = {word_hi_q, word_lo_q};
`else
   assign word       = {64'd0, word_lo_q};
`endif

endmodule

// File: tb/tb_siphash_gen2_core.sv
// Directed bench for siphash_gen2_core: RPC=1, RPC=2 and an odd-round RPC=2 instance
// driven in lockstep; the long-output checks follow SIPHASH_LONG_OUTPUT_EN.
module tb_siphash_gen2_core;

   localparam logic [127:0] K       = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [63:0]  M0      = 64'h0706050403020100;
   localparam logic [63:0]  M1      = 64'h0f0e0d0c0b0a0908;
   localparam logic [63:0]  E_EMPTY = 64'h726fdb47dd0e0e31;
   localparam logic [63:0]  E_15    = 64'ha129ca6149be45e5;
   localparam logic [127:0] E_LONG  = 128'h930255c71472f66d_e6a825ba047f81a3;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         initialize, compress, finalize, long_mode;
   logic [127:0] key;
   logic [63:0]  mi;
   logic         ready1, ready2, ready3;
   logic [127:0] word1, word2, word3;
   logic         valid1, valid2, valid3;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   siphash_gen2_core #(.C_ROUNDS(2), .D_ROUNDS(4), .RPC(1)) u_rpc1 (
      .clk(clk), .reset_n(reset_n), .initialize(initialize), .compress(compress),
      .finalize(finalize), .long_mode(long_mode), .key(key), .mi(mi),
      .ready(ready1), .word(word1), .word_valid(valid1));

   siphash_gen2_core #(.C_ROUNDS(2), .D_ROUNDS(4), .RPC(2)) u_rpc2 (
      .clk(clk), .reset_n(reset_n), .initialize(initialize), .compress(compress),
      .finalize(finalize), .long_mode(long_mode), .key(key), .mi(mi),
      .ready(ready2), .word(word2), .word_valid(valid2));

   siphash_gen2_core #(.C_ROUNDS(3), .D_ROUNDS(3), .RPC(2)) u_odd (
      .clk(clk), .reset_n(reset_n), .initialize(initialize), .compress(compress),
      .finalize(finalize), .long_mode(long_mode), .key(key), .mi(mi),
      .ready(ready3), .word(word3), .word_valid(valid3));

   // Reference SipHash for the odd-round instance, whose digests are not tabulated.
   function automatic logic [63:0] rl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   function automatic logic [255:0] m_round(input logic [255:0] s);
      logic [63:0] v0, v1, v2, v3;
      {v3, v2, v1, v0} = s;
      v0 = v0 + v1; v1 = rl(v1, 13); v1 = v1 ^ v0; v0 = rl(v0, 32);
      v2 = v2 + v3; v3 = rl(v3, 16); v3 = v3 ^ v2;
      v0 = v0 + v3; v3 = rl(v3, 21); v3 = v3 ^ v0;
      v2 = v2 + v1; v1 = rl(v1, 17); v1 = v1 ^ v2; v2 = rl(v2, 32);
      return {v3, v2, v1, v0};
   endfunction

   function automatic logic [127:0] ref_hash(input logic [127:0] k, input logic [63:0] m0,
                                             input logic [63:0] m1, input int n, input int c,
                                             input int d, input bit lng);
      logic [255:0] s;
      logic [63:0]  v0, v1, v2, v3, mw, lo, hi;
      v0 = k[63:0] ^ 64'h736f6d6570736575;
      v1 = k[127:64] ^ 64'h646f72616e646f6d ^ (lng ? 64'hee : 64'h0);
      v2 = k[63:0] ^ 64'h6c7967656e657261;
      v3 = k[127:64] ^ 64'h7465646279746573;
      for (int i = 0; i < n; i++) begin
         mw = (i == 0) ? m0 : m1;
         v3 = v3 ^ mw;
         s = {v3, v2, v1, v0};
         for (int r = 0; r < c; r++) s = m_round(s);
         {v3, v2, v1, v0} = s;
         v0 = v0 ^ mw;
      end
      v2 = v2 ^ (lng ? 64'hee : 64'hff);
      s = {v3, v2, v1, v0};
      for (int r = 0; r < d; r++) s = m_round(s);
      {v3, v2, v1, v0} = s;
      lo = v0 ^ v1 ^ v2 ^ v3;
      hi = 64'h0;
      if (lng) begin
         v1 = v1 ^ 64'hdd;
         s = {v3, v2, v1, v0};
         for (int r = 0; r < d; r++) s = m_round(s);
         {v3, v2, v1, v0} = s;
         hi = v0 ^ v1 ^ v2 ^ v3;
      end
      return {hi, lo};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic i, input logic c, input logic f, input logic lm,
                        input logic [63:0] m);
      initialize = i; compress = c; finalize = f; long_mode = lm; mi = m;
      @(posedge clk); #1;
      initialize = 1'b0; compress = 1'b0; finalize = 1'b0; long_mode = 1'b0;
   endtask

   // Cycles (acceptance cycle counted as 1) until each instance shows ready; 0 = timeout.
   task automatic settle(output int l1, output int l2, output int l3);
      l1 = 0; l2 = 0; l3 = 0;
      for (int k = 1; k <= 60; k++) begin
         if (l1 == 0 && ready1) l1 = k;
         if (l2 == 0 && ready2) l2 = k;
         if (l3 == 0 && ready3) l3 = k;
         if (l1 != 0 && l2 != 0 && l3 != 0) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic op(input logic i, input logic c, input logic f, input logic lm,
                     input logic [63:0] m, output int l1, output int l2, output int l3);
      pulse(i, c, f, lm, m);
      settle(l1, l2, l3);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int l1, l2, l3;
      logic lng;
`ifdef SIPHASH_LONG_OUTPUT_EN
      lng = 1'b1;
`else
      lng = 1'b0;
`endif
      reset_n = 1'b0; initialize = 1'b0; compress = 1'b0; finalize = 1'b0;
      long_mode = 1'b0; key = K; mi = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 128'({ready1, ready2, ready3}), 128'(3'b111));
      chk("reset_word", word1 | word2 | word3, 128'd0);
      chk("reset_valid", 128'({valid1, valid2, valid3}), 128'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // empty message: one compress of the length block, then finalize
      op(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, l1, l2, l3);
      chk("init_lat", 128'(l1), 128'd1);
      op(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, l1, l2, l3);
      chk("comp_lat_rpc1", 128'(l1), 128'd4);
      chk("comp_lat_rpc2", 128'(l2), 128'd3);
      chk("comp_lat_odd", 128'(l3), 128'd4);
      op(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, l1, l2, l3);
      chk("fin_lat_rpc1", 128'(l1), 128'd6);
      chk("fin_lat_rpc2", 128'(l2), 128'd4);
      chk("fin_lat_odd", 128'(l3), 128'd4);
      chk("empty_rpc1", word1, {64'd0, E_EMPTY});
      chk("empty_rpc2", word2, {64'd0, E_EMPTY});
      chk("empty_odd", word3, ref_hash(K, 64'd0, 64'd0, 1, 3, 3, 1'b0));
      chk("empty_valid", 128'({valid1, valid2, valid3}), 128'(3'b111));

      // 15-byte message
      op(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, l1, l2, l3);
      op(1'b0, 1'b1, 1'b0, 1'b0, M0, l1, l2, l3);
      op(1'b0, 1'b1, 1'b0, 1'b0, M1, l1, l2, l3);
      op(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, l1, l2, l3);
      chk("msg15_rpc1", word1, {64'd0, E_15});
      chk("msg15_rpc2", word2, {64'd0, E_15});
      chk("msg15_odd", word3, ref_hash(K, M0, M1, 2, 3, 3, 1'b0));

      // compress after finalize without initialize drops word_valid
      op(1'b0, 1'b1, 1'b0, 1'b0, 64'h1234, l1, l2, l3);
      chk("recompress_valid", 128'({valid1, valid2, valid3}), 128'd0);

      // compress wins over finalize; finalize while busy is ignored
      op(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, l1, l2, l3);
      pulse(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
      settle(l1, l2, l3);
      chk("prio_lat_rpc1", 128'(l1), 128'd3);
      chk("prio_valid", 128'({valid1, valid2, valid3}), 128'd0);
      op(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, l1, l2, l3);
      chk("prio_digest_rpc1", word1, {64'd0, E_EMPTY});
      chk("prio_digest_rpc2", word2, {64'd0, E_EMPTY});

      // long_mode request: 128-bit digest when enabled, otherwise ignored
      op(1'b1, 1'b0, 1'b0, 1'b1, 64'd0, l1, l2, l3);
      op(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, l1, l2, l3);
      op(1'b0, 1'b0, 1'b1, 1'b1, 64'd0, l1, l2, l3);
      chk("long_rpc1", word1, lng ? E_LONG : {64'd0, E_EMPTY});
      chk("long_rpc2", word2, lng ? E_LONG : {64'd0, E_EMPTY});
      chk("long_odd", word3, ref_hash(K, 64'd0, 64'd0, 1, 3, 3, lng));
      chk("long_valid", 128'({valid1, valid2, valid3}), 128'(3'b111));

      // asynchronous reset in the middle of finalization
      op(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, l1, l2, l3);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
      @(posedge clk); #1;
      chk("midfin_busy", 128'({ready1, ready2, ready3}), 128'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("midfin_reset_ready", 128'({ready1, ready2, ready3}), 128'(3'b111));
      chk("midfin_reset_word", word1 | word2 | word3, 128'd0);
      chk("midfin_reset_valid", 128'({valid1, valid2, valid3}), 128'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      op(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, l1, l2, l3);
      op(1'b0, 1'b1, 1'b0, 1'b0, M0, l1, l2, l3);
      op(1'b0, 1'b1, 1'b0, 1'b0, M1, l1, l2, l3);
      op(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, l1, l2, l3);
      chk("post_reset_rpc1", word1, {64'd0, E_15});
      chk("post_reset_rpc2", word2, {64'd0, E_15});
      chk("post_reset_odd", word3, ref_hash(K, M0, M1, 2, 3, 3, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
